reel_spinner: RTL and testbench
===============================

# reel_spinner

Reel controller and result source for the slot machine datapath. It accepts a debounced spin request, animates four decimal reels, and stops them one after another at pseudo-random positions. It then presents the four results as active-low 7-segment patterns on `num1`..`num4`. It raises `to_score` once per spin, telling the scoring stage to evaluate the match and apply the bet.

## Interface
- `STEP_DIV`, 5_000_000: clock cycles per reel tick (20 Hz at 100 MHz); minimum 2.
- `BASE_TICKS`, 20: minimum tick count before reel 1 stops; minimum 1.
- `STOP_GAP`, 8: ticks between successive reel stops; minimum 1.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `spin`  in  1  spin button level, asynchronous to `clk`.
- `bet_ok`  in  1  high when the player can afford a spin (score >= 10, i.e. not broke).
- `num1`..`num4`  out  7 each  reel digit as active-low 7-seg pattern {g..a}.
- `to_score`  out  1  result valid; held high until the next accepted spin.
- `spinning`  out  1  high while any reel is moving.

## Operation
- Digit encoding:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Each reel is held internally as a 4-bit value 0..9 and decoded combinationally from registered values.
- Spin input: two-flop synchronizer, then a registered rising-edge detect. One press yields one request regardless of hold length.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Seeded 0xACE1 on reset and advances every clock. It never reaches all-zero.
- States: IDLE, SPIN, RESULT.
  - IDLE: wait for request with `bet_ok`=1, then go to SPIN. A request with `bet_ok`=0 is dropped.
  - SPIN entry: clear the tick divider and tick count. Latch `stop_tick = BASE_TICKS + lfsr[3:0]`. Clear the stopped mask.
  - Tick: pulse when the divider reaches STEP_DIV-1, then wrap the divider to 0. The tick count t increments, starting at 1 for the first tick.
  - On each tick, every unstopped reel k (0..3) advances by stride 1, 3, 7, 9 respectively, mod 10. The wrap uses a subtract of 10, never `%`.
  - Reel k advances on tick t == `stop_tick + k*STOP_GAP` and then freezes.
  - After reel 3 freezes: go to RESULT and set `to_score`.
  - RESULT: outputs held. A request with `bet_ok`=1 clears `to_score` and enters SPIN. A request with `bet_ok`=0 is dropped, leaving the machine in RESULT.
- Requests arriving during SPIN are ignored, not queued.
- `bet_ok` is sampled only at acceptance; changes mid-spin have no effect.

## Timing
- Reset values:
  - Every reel is 0, so `num1`..`num4` = 1000000.
  - `to_score`=0, `spinning`=0, state IDLE, LFSR 0xACE1, synchronizer flops 0.
- Acceptance: state becomes SPIN and `spinning` goes high at the 3rd rising `clk` edge after `spin` rises. This assumes setup is met at the first edge.
- First tick occurs STEP_DIV cycles after SPIN entry.
- Last reel freezes STEP_DIV*(stop_tick + 3*STOP_GAP) cycles after SPIN entry.
- `to_score` rises and `spinning` falls on the clock edge after that freeze. `num1`..`num4` are already final on that same edge.
- `to_score` falls on the acceptance edge of the next spin, so it is low for the whole SPIN state. This gives the scoring stage at least STEP_DIV low cycles to re-arm.
- A reset asserted mid-spin immediately forces all reset values. No partial result is ever flagged.
- Reel values change only on tick edges; `num*` outputs are glitch-free at the register level.

## Test plan
- Reset with `spin` held low for 100 cycles:
  - All `num*` = 1000000, `to_score`=0, `spinning`=0.
- STEP_DIV=2, BASE_TICKS=4, STOP_GAP=2, `bet_ok`=1, pulse `spin`:
  - `spinning` rises on the 3rd edge.
  - `to_score` rises exactly 2*(stop_tick+6)+1 cycles after SPIN entry, where stop_tick = 4 + the probed lfsr[3:0].
  - Reel k final value = (stride_k * (stop_tick + k*2)) mod 10, decoded per the table.
- Same setup, with `spin` held high for 1000 cycles and re-pulsed during SPIN:
  - Exactly one spin occurs; `to_score` rises once.
- `bet_ok`=0, pulse `spin` in IDLE and again in RESULT:
  - No state change; `to_score` stays at its prior value; reels are unchanged.
- From RESULT, pulse `spin` with `bet_ok`=1:
  - `to_score` drops on the acceptance edge and stays low until the next result.
  - Reels restart from their previous values.
- Deassert `rst_n` mid-spin after reel 1 freezes:
  - All outputs return to reset values asynchronously. After release, no `to_score` occurs until a new press.

Source files
------------

// File: rtl/reel_spinner.sv
// Four-reel slot machine spinner: synchronised spin request, LFSR-driven stop
// schedule, staggered reel freezes and active-low 7-segment result outputs.
module reel_spinner #(
   parameter int STEP_DIV   = 5_000_000,
   parameter int BASE_TICKS = 20,
   parameter int STOP_GAP   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spin,
   input  logic       bet_ok,
   output logic [6:0] num1,
   output logic [6:0] num2,
   output logic [6:0] num3,
   output logic [6:0] num4,
   output logic       to_score,
   output logic       spinning
);

   localparam int MAX_TICK = BASE_TICKS + 15 + 3 * STOP_GAP;
   localparam int TW       = $clog2(MAX_TICK + 1);
   localparam int DW       = $clog2(STEP_DIV);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SPIN,
      ST_RESULT
   } state_t;

   state_t          r_state;
   logic            r_sync1;
   logic            r_sync2;
   logic            r_sync3;
   logic [15:0]     r_lfsr;
   logic [DW-1:0]   r_div;
   logic [TW-1:0]   r_tick_cnt;
   logic [TW-1:0]   r_stop_tick;
   logic [3:0]      r_stopped;
   logic            r_to_score;
   logic            r_spinning;
   logic [3:0]      r_reel [4];

   logic            w_req;
   logic            w_tick;
   logic            w_lfsr_fb;
   logic [TW-1:0]   w_tick_next;
   logic [3:0]      w_hit;
   logic [6:0]      w_seg [4];

   // Rising edge of the synchronised button level; one request per press.
   assign w_req       = r_sync2 & ~r_sync3;
   assign w_tick      = (r_div == DW'(STEP_DIV - 1));
   assign w_tick_next = r_tick_cnt + TW'(1);
   assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
         r_lfsr  <= 16'hACE1;
      end else begin
         r_sync1 <= spin;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_lfsr  <= {w_lfsr_fb, r_lfsr[15:1]};
      end
   end

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_reel
         localparam int STRIDE = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 7 : 9;

         logic [TW-1:0] w_target;
         logic [4:0]    w_sum;
         logic [3:0]    w_next;

         assign w_target   = r_stop_tick + TW'(gi * STOP_GAP);
         assign w_sum      = {1'b0, r_reel[gi]} + 5'(STRIDE);
         assign w_next     = (w_sum >= 5'd10) ? 4'(w_sum - 5'd10) : w_sum[3:0];
         // Reel takes its final step on the target tick and freezes after it.
         assign w_hit[gi]  = ~r_stopped[gi] & (w_tick_next == w_target);
         assign w_seg[gi]  = seg_decode(r_reel[gi]);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_reel[gi] <= 4'd0;
            end else if (r_state == ST_SPIN && w_tick && !r_stopped[gi]) begin
               r_reel[gi] <= w_next;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_div       <= '0;
         r_tick_cnt  <= '0;
         r_stop_tick <= '0;
         r_stopped   <= 4'b0000;
         r_to_score  <= 1'b0;
         r_spinning  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_RESULT: begin
               // bet_ok matters only here; unaffordable requests are dropped.
               if (w_req && bet_ok) begin
                  r_state     <= ST_SPIN;
                  r_div       <= '0;
                  r_tick_cnt  <= '0;
                  r_stop_tick <= TW'(BASE_TICKS) + TW'(r_lfsr[3:0]);
                  r_stopped   <= 4'b0000;
                  r_to_score  <= 1'b0;
                  r_spinning  <= 1'b1;
               end
            end
            ST_SPIN: begin
               if (&r_stopped) begin
                  r_state    <= ST_RESULT;
                  r_to_score <= 1'b1;
                  r_spinning <= 1'b0;
               end else if (w_tick) begin
                  r_div      <= '0;
                  r_tick_cnt <= w_tick_next;
                  r_stopped  <= r_stopped | w_hit;
               end else begin
                  r_div <= r_div + DW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign num1     = w_seg[0];
   assign num2     = w_seg[1];
   assign num3     = w_seg[2];
   assign num4     = w_seg[3];
   assign to_score = r_to_score;
   assign spinning = r_spinning;

endmodule

// File: tb/tb_reel_spinner.sv
// Randomised directed bench for reel_spinner with a cycle-level reference of
// the stop schedule, reel arithmetic and to_score/spinning timing.
module tb_reel_spinner;

   localparam int STEP_DIV   = 2;
   localparam int BASE_TICKS = 4;
   localparam int STOP_GAP   = 2;

   logic       clk;
   logic       rst_n;
   logic       spin;
   logic       bet_ok;
   logic [6:0] num1, num2, num3, num4;
   logic       to_score;
   logic       spinning;

   int checks = 0;
   int errors = 0;

   int          m_reel [4];
   bit          m_to_score;
   logic [15:0] m_lfsr;

   const int STRIDE [4] = '{1, 3, 7, 9};
   logic [6:0] seg_tab [10];

   reel_spinner #(
      .STEP_DIV  (STEP_DIV),
      .BASE_TICKS(BASE_TICKS),
      .STOP_GAP  (STOP_GAP)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .spin    (spin),
      .bet_ok  (bet_ok),
      .num1    (num1),
      .num2    (num2),
      .num3    (num3),
      .num4    (num4),
      .to_score(to_score),
      .spinning(spinning)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      logic [15:0] fb;
      fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
      return (l >> 1) | (fb << 15);
   endfunction

   // Free-running reference LFSR: seeded on reset, one step per clock.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= lfsr_step(m_lfsr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reels(input string tag);
      chk({tag, "_num1"}, num1, seg_tab[m_reel[0]]);
      chk({tag, "_num2"}, num2, seg_tab[m_reel[1]]);
      chk({tag, "_num3"}, num3, seg_tab[m_reel[2]]);
      chk({tag, "_num4"}, num4, seg_tab[m_reel[3]]);
   endtask

   // One press: spin held for 'hold' cycles, optional second press mid-spin,
   // optional reset once reel 1 has frozen.
   task automatic press(input int hold, input bit bet, input bit repulse, input bit abort);
      logic [15:0] l;
      int stop, total, cnt, abort_at;
      bit prev_ts;
      prev_ts = m_to_score;
      @(negedge clk);
      spin   = 1'b1;
      bet_ok = bet;
      @(negedge clk);
      @(negedge clk);
      l = m_lfsr;
      chk("pre_accept_spinning", spinning, 1'b0);
      @(negedge clk);
      cnt = 3;
      if (!bet) begin
         chk("drop_spinning", spinning, 1'b0);
         chk("drop_to_score", to_score, prev_ts);
         chk_reels("drop");
      end else begin
         chk("accept_spinning", spinning, 1'b1);
         chk("accept_to_score", to_score, 1'b0);
         m_to_score = 1'b0;
         stop     = BASE_TICKS + int'(l[3:0]);
         total    = STEP_DIV * (stop + 3 * STOP_GAP);
         abort_at = STEP_DIV * (stop + STOP_GAP) + 1;
         for (int c = 1; c <= total + 1; c++) begin
            spin = (cnt < hold) || (repulse && c >= total / 2 && c <= total / 2 + 2);
            bet_ok = 1'($urandom);
            if (abort && c == abort_at) begin
               rst_n = 1'b0;
               #1;
               for (int k = 0; k < 4; k++) m_reel[k] = 0;
               m_to_score = 1'b0;
               chk_reels("async_reset");
               chk("async_reset_to_score", to_score, 1'b0);
               chk("async_reset_spinning", spinning, 1'b0);
               spin = 1'b0;
               repeat (3) @(negedge clk);
               rst_n = 1'b1;
               repeat (40) @(negedge clk);
               chk("post_reset_to_score", to_score, 1'b0);
               chk("post_reset_spinning", spinning, 1'b0);
               chk_reels("post_reset");
               return;
            end
            @(negedge clk);
            cnt++;
            chk("spin_timing", {to_score, spinning}, {c > total, c <= total});
         end
         for (int k = 0; k < 4; k++)
            m_reel[k] = (m_reel[k] + STRIDE[k] * (stop + k * STOP_GAP)) % 10;
         m_to_score = 1'b1;
         chk_reels("result");
      end
      while (cnt < hold) begin
         @(negedge clk);
         cnt++;
      end
      spin = 1'b0;
      repeat (4) @(negedge clk);
      chk("settle_to_score", to_score, m_to_score);
      chk("settle_spinning", spinning, 1'b0);
      $display("press hold=%0d bet=%0b repulse=%0b abort=%0b lfsr_lo=%0d to_score=%0b reels=%0d%0d%0d%0d",
               hold, bet, repulse, abort, l[3:0], to_score, m_reel[0], m_reel[1], m_reel[2], m_reel[3]);
   endtask

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      for (int k = 0; k < 4; k++) m_reel[k] = 0;
      m_to_score = 1'b0;
      spin   = 1'b0;
      bet_ok = 1'b0;
      rst_n  = 1'b0;
      repeat (100) @(negedge clk);
      chk_reels("reset");
      chk("reset_to_score", to_score, 1'b0);
      chk("reset_spinning", spinning, 1'b0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      press(2, 1'b1, 1'b0, 1'b0);       // basic spin from IDLE
      press(2, 1'b0, 1'b0, 1'b0);       // unaffordable press in RESULT
      press(1000, 1'b1, 1'b1, 1'b0);    // long hold plus mid-spin re-press
      press(3, 1'b1, 1'b0, 1'b1);       // reset after reel 1 freezes
      press(2, 1'b0, 1'b0, 1'b0);       // unaffordable press in IDLE
      press(5, 1'b1, 1'b1, 1'b0);       // short press, re-press during SPIN

      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 40)) @(negedge clk);
         press($urandom_range(1, 60), ($urandom_range(0, 9) < 7), 1'($urandom), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
